alu_issue_stage: RTL and testbench



---
 rtl/alu_issue_stage.sv | 199 +++++++++++++++++++
 tb/tb_alu_issue_stage.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// Decode/issue stage feeding the ALU: registered operands, ALU code and writeback info.
// Optional illegal-instruction flag output enabled by defining BURAQ_ILLEGAL_TRAP_EN.
module alu_issue_stage #(
    parameter int DataWidth = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_in_valid,
    output logic                 o_in_ready,
    input  logic [DataWidth-1:0] i_instr,
    input  logic [DataWidth-1:0] i_pc,
    input  logic [DataWidth-1:0] i_rs1_data,
    input  logic [DataWidth-1:0] i_rs2_data,
    input  logic                 i_flush,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output logic [DataWidth-1:0] o_operand_A,
    output logic [DataWidth-1:0] o_operand_B,
    output logic [5:0]           o_ALU_Control,
    output logic [4:0]           o_rd_addr,
    output logic                 o_reg_write
`ifdef BURAQ_ILLEGAL_TRAP_EN
    ,
    output logic                 o_illegal_insn
`endif
);

    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;

    logic [6:0]           w_opc;
    logic [2:0]           w_f3;
    logic [6:0]           w_f7;
    logic [4:0]           w_rd;
    logic [DataWidth-1:0] w_imm_i;
    logic [DataWidth-1:0] w_imm_s;
    logic [DataWidth-1:0] w_imm_u;
    logic [DataWidth-1:0] w_pc4;

    logic [DataWidth-1:0] w_a;
    logic [DataWidth-1:0] w_b;
    logic [5:0]           w_code;
    logic                 w_wr;
    logic                 w_ill;
    logic                 w_rw;
    logic                 w_cap;

    logic                 r_valid;
    logic [DataWidth-1:0] r_a;
    logic [DataWidth-1:0] r_b;
    logic [5:0]           r_code;
    logic [4:0]           r_rd;
    logic                 r_rw;
`ifdef BURAQ_ILLEGAL_TRAP_EN
    logic                 r_ill;
`endif

    assign w_opc   = i_instr[6:0];
    assign w_f3    = i_instr[14:12];
    assign w_f7    = i_instr[31:25];
    assign w_rd    = i_instr[11:7];
    assign w_imm_i = DataWidth'($signed(i_instr[31:20]));
    assign w_imm_s = DataWidth'($signed({i_instr[31:25], i_instr[11:7]}));
    assign w_imm_u = DataWidth'($signed({i_instr[31:12], 12'h000}));
    assign w_pc4   = i_pc + DataWidth'(4);

    // Combinational RV32I decode into operands, ALU code and rd-write intent
    always_comb begin
        w_a    = '0;
        w_b    = '0;
        w_code = 6'b000000;
        w_wr   = 1'b0;
        w_ill  = 1'b0;
        case (w_opc)
            OpcOp: begin
                w_a    = i_rs1_data;
                w_b    = i_rs2_data;
                w_code = {2'b00, w_f7[5], w_f3};
                w_wr   = 1'b1;
                if (w_f7 == 7'h20) begin
                    w_ill = !((w_f3 == 3'b000) || (w_f3 == 3'b101));
                end else begin
                    w_ill = (w_f7 != 7'h00);
                end
            end
            OpcOpImm: begin
                w_a    = i_rs1_data;
                w_b    = w_imm_i;
                w_code = {3'b000, w_f3};
                w_wr   = 1'b1;
                if (w_f3 == 3'b001) begin
                    w_ill = (w_f7 != 7'h00);
                end else if (w_f3 == 3'b101) begin
                    w_code = {2'b00, i_instr[30], w_f3};
                    w_ill  = !((w_f7 == 7'h00) || (w_f7 == 7'h20));
                end
            end
            OpcBranch: begin
                w_a    = i_rs1_data;
                w_b    = i_rs2_data;
                w_code = {3'b010, w_f3};
                w_ill  = (w_f3 == 3'b010) || (w_f3 == 3'b011);
            end
            OpcJal: begin
                w_a    = w_pc4;
                w_code = 6'b011111;
                w_wr   = 1'b1;
            end
            OpcJalr: begin
                w_a    = w_pc4;
                w_code = 6'b011111;
                w_wr   = 1'b1;
                w_ill  = (w_f3 != 3'b000);
            end
            OpcLui: begin
                w_b  = w_imm_u;
                w_wr = 1'b1;
            end
            OpcAuipc: begin
                w_a  = i_pc;
                w_b  = w_imm_u;
                w_wr = 1'b1;
            end
            OpcLoad: begin
                w_a   = i_rs1_data;
                w_b   = w_imm_i;
                w_wr  = 1'b1;
                w_ill = (w_f3 == 3'b011) || (w_f3 == 3'b110) ||
                        (w_f3 == 3'b111);
            end
            OpcStore: begin
                w_a   = i_rs1_data;
                w_b   = w_imm_s;
                w_ill = (w_f3 > 3'b010);
            end
            default: begin
                w_ill = 1'b1;
            end
        endcase
        // Illegal decodes issue as a harmless ADD 0+0 with no writeback
        if (w_ill) begin
            w_a    = '0;
            w_b    = '0;
            w_code = 6'b000000;
            w_wr   = 1'b0;
        end
    end

    assign w_rw       = w_wr && (w_rd != 5'd0);
    assign o_in_ready = !r_valid || i_out_ready;
    assign w_cap      = i_in_valid && o_in_ready && !i_flush;

    // Issue register: flush beats capture, capture beats drain
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_code  <= '0;
            r_rd    <= '0;
            r_rw    <= 1'b0;
`ifdef BURAQ_ILLEGAL_TRAP_EN
            r_ill   <= 1'b0;
`endif
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (w_cap) begin
            r_valid <= 1'b1;
            r_a     <= w_a;
            r_b     <= w_b;
            r_code  <= w_code;
            r_rd    <= w_rd;
            r_rw    <= w_rw;
`ifdef BURAQ_ILLEGAL_TRAP_EN
            r_ill   <= w_ill;
`endif
        end else if (i_out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_out_valid   = r_valid;
    assign o_operand_A   = r_a;
    assign o_operand_B   = r_b;
    assign o_ALU_Control = r_code;
    assign o_rd_addr     = r_rd;
    assign o_reg_write   = r_rw;
`ifdef BURAQ_ILLEGAL_TRAP_EN
    assign o_illegal_insn = r_ill;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed RV32I vectors,
// stall, flush and mid-stall reset.
module tb_alu_issue_stage;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  code;
        logic [4:0]  rd;
        logic        rw;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = '0;
    logic [31:0] pc = '0;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [5:0]  code;
    logic [4:0]  rd;
    logic        rw;
`ifdef BURAQ_ILLEGAL_TRAP_EN
    logic        ill;
`endif

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    alu_issue_stage #(.DataWidth(32)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_in_valid   (in_valid),
        .o_in_ready   (in_ready),
        .i_instr      (instr),
        .i_pc         (pc),
        .i_rs1_data   (rs1),
        .i_rs2_data   (rs2),
        .i_flush      (flush),
        .o_out_valid  (out_valid),
        .i_out_ready  (out_ready),
        .o_operand_A  (op_a),
        .o_operand_B  (op_b),
        .o_ALU_Control(code),
        .o_rd_addr    (rd),
        .o_reg_write  (rw)
`ifdef BURAQ_ILLEGAL_TRAP_EN
        ,
        .o_illegal_insn(ill)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] a, input logic [31:0] b,
                                input logic [5:0] c, input logic [4:0] d,
                                input logic w, input logic il);
        exp_t e;
        e.a = a; e.b = b; e.code = c; e.rd = d; e.rw = w; e.ill = il;
        return e;
    endfunction

    // Monitor: every accepted output is popped and compared
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("operand_A", op_a, e.a);
                chk("operand_B", op_b, e.b);
                chk("ALU_Control", {26'd0, code}, {26'd0, e.code});
                chk("rd_addr", {27'd0, rd}, {27'd0, e.rd});
                chk("reg_write", {31'd0, rw}, {31'd0, e.rw});
`ifdef BURAQ_ILLEGAL_TRAP_EN
                chk("illegal_insn", {31'd0, ill}, {31'd0, e.ill});
`endif
            end
        end
    end

    // Present one instruction; called just after a rising edge
    task automatic send(input logic [31:0] ins, input logic [31:0] p,
                        input logic [31:0] a, input logic [31:0] b,
                        input exp_t e);
        int n;
        in_valid = 1'b1;
        instr = ins; pc = p; rs1 = a; rs2 = b;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 20);
        if (!in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
        else sb.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int n;
        in_valid = 1'b0;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_left", sb.size(), 32'd0);
    endtask

    logic il_exp;

    initial begin
`ifdef BURAQ_ILLEGAL_TRAP_EN
        il_exp = 1'b1;
`else
        il_exp = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_A", op_a, 32'd0);
        chk("rst_B", op_b, 32'd0);
        chk("rst_code", {26'd0, code}, 32'd0);
        chk("rst_rw", {31'd0, rw}, 32'd0);
        @(posedge clk); #1;

        // Back-to-back stream at full throughput
        out_ready = 1'b1;
        send(32'h002081B3, 32'h0, 32'd5, 32'd7, mk(5, 7, 6'b000000, 3, 1, 0));
        send(32'h402081B3, 32'h0, 32'd10, 32'd3, mk(10, 3, 6'b001000, 3, 1, 0));
        send(32'h40335293, 32'h0, 32'h80000000, 32'd0,
             mk(32'h80000000, 32'h403, 6'b001101, 5, 1, 0));
        send(32'h00335293, 32'h0, 32'd64, 32'd0, mk(64, 3, 6'b000101, 5, 1, 0));
        send(32'h00208063, 32'h0, 32'd9, 32'd9, mk(9, 9, 6'b010000, 0, 0, 0));
        send(32'h0020C063, 32'h0, 32'hFFFFFFFF, 32'd1,
             mk(32'hFFFFFFFF, 1, 6'b010100, 0, 0, 0));
        send(32'h000000EF, 32'h100, 32'd0, 32'd0, mk(32'h104, 0, 6'b011111, 1, 1, 0));
        send(32'h0000006F, 32'hFFFFFFFC, 32'd0, 32'd0, mk(0, 0, 6'b011111, 0, 0, 0));
        send(32'h123453B7, 32'h0, 32'd1, 32'd2, mk(0, 32'h12345000, 6'b000000, 7, 1, 0));
        send(32'hFFFFF417, 32'h200, 32'd1, 32'd2,
             mk(32'h200, 32'hFFFFF000, 6'b000000, 8, 1, 0));
        send(32'hFFF00093, 32'h0, 32'h10, 32'd0,
             mk(32'h10, 32'hFFFFFFFF, 6'b000000, 1, 1, 0));
        send(32'h0050A313, 32'h0, 32'd3, 32'd0, mk(3, 5, 6'b000010, 6, 1, 0));
        send(32'hFE20AE23, 32'h0, 32'h1000, 32'd4,
             mk(32'h1000, 32'hFFFFFFFC, 6'b000000, 5'h1C, 0, 0));
        send(32'h0080A203, 32'h0, 32'h2000, 32'd0, mk(32'h2000, 8, 6'b000000, 4, 1, 0));
        send(32'h00208033, 32'h0, 32'd1, 32'd2, mk(1, 2, 6'b000000, 0, 0, 0));
        send(32'h0000017F, 32'h0, 32'd11, 32'd12, mk(0, 0, 6'b000000, 2, 0, il_exp));
        send(32'h40209133, 32'h0, 32'd11, 32'd12, mk(0, 0, 6'b000000, 2, 0, il_exp));
        drain();

        // Stall: held entry must stay stable and block input
        out_ready = 1'b0;
        send(32'h002081B3, 32'h0, 32'd5, 32'd7, mk(5, 7, 6'b000000, 3, 1, 0));
        in_valid = 1'b0;
        instr = 32'h402081B3; rs1 = 32'd99; rs2 = 32'd98;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_A", op_a, 32'd5);
            chk("stall_B", op_b, 32'd7);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send(32'h402081B3, 32'h0, 32'd20, 32'd6, mk(20, 6, 6'b001000, 3, 1, 0));
        drain();

        // Flush with a held entry and a new incoming instruction
        out_ready = 1'b0;
        send(32'h002081B3, 32'h0, 32'd1, 32'd1, mk(1, 1, 6'b000000, 3, 1, 0));
        in_valid = 1'b1;
        instr = 32'h402081B3; rs1 = 32'd4; rs2 = 32'd2;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        void'(sb.pop_back());
        @(negedge clk);
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;

        // Reset while stalled discards the entry
        send(32'h123453B7, 32'h0, 32'd0, 32'd0, mk(0, 32'h12345000, 6'b000000, 7, 1, 0));
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        void'(sb.pop_back());
        @(negedge clk);
        chk("rst2_valid", {31'd0, out_valid}, 32'd0);
        chk("rst2_B", op_b, 32'd0);
        chk("rst2_rd", {27'd0, rd}, 32'd0);
        chk("rst2_rw", {31'd0, rw}, 32'd0);
        @(posedge clk); #1;

        // Normal operation resumes after reset
        out_ready = 1'b1;
        send(32'h002081B3, 32'h0, 32'd40, 32'd2, mk(40, 2, 6'b000000, 3, 1, 0));
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
